// File: rtl/prog_ram_loader.sv
// prog_ram_loader: writable 16x8 TD4 program store with a valid/ready byte loader.
// Start clears every word, then accepts up to 16 bytes, ending on WrLast or the top address.
// The CPU is held in reset until a load has completed.
module prog_ram_loader #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              Start,
    input  logic [DATA_W-1:0] WrData,
    input  logic              WrValid,
    input  logic              WrLast,
    output logic              WrReady,
    input  logic [ADDR_W-1:0] In,
    output logic [DATA_W-1:0] Out,
    output logic              CpuReset,
    output logic              Loading,
    output logic              Done,
    output logic [ADDR_W:0]   ByteCount
);

    localparam int Depth = 1 << ADDR_W;

    typedef enum logic [1:0] {StIdle, StClear, StLoad, StDone} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] mem_q [Depth];
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              we;
    logic [DATA_W-1:0] wdata;
    logic              addr_last;

    assign addr_last = (addr_q == {ADDR_W{1'b1}});

    // Next-state, write-enable and address/count sequencing.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        we      = 1'b0;
        wdata   = WrData;
        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    state_d = StClear;
                    addr_d  = '0;
                    count_d = '0;
                end
            end
            StClear: begin
                // Zero one word per cycle; the top address hands over to LOAD.
                we     = 1'b1;
                wdata  = '0;
                addr_d = addr_q + 1'b1;
                if (addr_last) begin
                    state_d = StLoad;
                    addr_d  = '0;
                end
            end
            StLoad: begin
                if (WrValid) begin
                    we      = 1'b1;
                    addr_d  = addr_q + 1'b1;
                    count_d = count_q + 1'b1;
                    // The top address ends the load so address 0 is never overwritten.
                    if (WrLast || addr_last) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (Start) begin
                    state_d = StClear;
                    addr_d  = '0;
                    count_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, address, count and memory registers; synchronous reset clears memory too.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= StIdle;
            addr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            if (we) begin
                mem_q[addr_q] <= wdata;
            end
        end
    end

    // Output decodes from registered state; the read port is purely combinational.
    always_comb begin
        WrReady   = (state_q == StLoad);
        Loading   = (state_q == StClear) || (state_q == StLoad);
        Done      = (state_q == StDone);
        CpuReset  = (state_q != StDone);
        ByteCount = count_q;
        Out       = mem_q[In];
    end

endmodule

// File: tb/tb_prog_ram_loader.sv
// Bench for prog_ram_loader: directed and randomized loads against an expected-memory model.
module tb_prog_ram_loader;

    logic       CLK = 1'b0;
    logic       Reset;
    logic       Start;
    logic [7:0] WrData;
    logic       WrValid;
    logic       WrLast;
    logic       WrReady;
    logic [3:0] In;
    logic [7:0] Out;
    logic       CpuReset;
    logic       Loading;
    logic       Done;
    logic [4:0] ByteCount;

    int errors = 0;
    int checks = 0;

    bit [7:0] data [16];
    bit [7:0] exp_mem [16];

    prog_ram_loader #(.ADDR_W(4), .DATA_W(8)) dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .Start    (Start),
        .WrData   (WrData),
        .WrValid  (WrValid),
        .WrLast   (WrLast),
        .WrReady  (WrReady),
        .In       (In),
        .Out      (Out),
        .CpuReset (CpuReset),
        .Loading  (Loading),
        .Done     (Done),
        .ByteCount(ByteCount)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_mem(input string tag);
        for (int a = 0; a < 16; a++) begin
            In = 4'(a);
            #1;
            chk(tag, {24'd0, Out}, {24'd0, exp_mem[a]});
        end
    endtask

    // Start a load; during CLEAR, drive junk bytes and a stray Start that must be ignored.
    task automatic start_and_clear();
        int cyc;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        chk("clear_loading", Loading, 1);
        chk("clear_wrready", WrReady, 0);
        cyc = 0;
        while (WrReady !== 1'b1 && cyc < 40) begin
            chk("clear_cpureset", CpuReset, 1);
            WrValid = 1'b1;
            WrData  = 8'($urandom);
            WrLast  = 1'b1;
            Start   = (cyc == 3);
            tick();
            cyc++;
        end
        Start   = 1'b0;
        WrValid = 1'b0;
        WrLast  = 1'b0;
        chk("wrready_latency", cyc, 16);
    endtask

    // Feed data[0..n-1]; optional stall pattern 1,0,0,... with a Start on a stall cycle.
    task automatic run_load(input int n, input bit use_last, input bit stall);
        int i;
        int k;
        start_and_clear();
        i = 0;
        k = 0;
        while (i < n && k < 100) begin
            chk("load_cpureset", CpuReset, 1);
            chk("load_wrready", WrReady, 1);
            WrValid = stall ? (k % 3 == 0) : 1'b1;
            WrData  = data[i];
            WrLast  = use_last && (i == n - 1);
            Start   = stall && (k == 1);
            tick();
            if (WrValid) i++;
            k++;
            if (i < n) chk("bytecount_mid", ByteCount, i);
        end
        WrValid = 1'b0;
        WrLast  = 1'b0;
        Start   = 1'b0;
        chk("bytes_fed", i, n);
        chk("done", Done, 1);
        chk("done_cpureset", CpuReset, 0);
        chk("done_wrready", WrReady, 0);
        chk("done_loading", Loading, 0);
        chk("done_bytecount", ByteCount, n);
        // A byte offered in DONE must be ignored.
        WrValid = 1'b1;
        WrData  = 8'h5A;
        tick();
        WrValid = 1'b0;
        chk("done_hold_count", ByteCount, n);
        chk("done_hold", Done, 1);
        for (int a = 0; a < 16; a++) exp_mem[a] = (a < n) ? data[a] : 8'h00;
        check_mem("mem");
    endtask

    initial begin
        Reset   = 1'b1;
        Start   = 1'b0;
        WrData  = 8'h00;
        WrValid = 1'b0;
        WrLast  = 1'b0;
        In      = 4'h0;
        tick();
        Reset = 1'b0;
        chk("rst_cpureset", CpuReset, 1);
        chk("rst_done", Done, 0);
        chk("rst_wrready", WrReady, 0);
        chk("rst_loading", Loading, 0);
        chk("rst_bytecount", ByteCount, 0);
        for (int a = 0; a < 16; a++) exp_mem[a] = 8'h00;
        check_mem("rst_mem");

        // Full timer program, WrValid held high, no WrLast.
        data = '{8'hB7, 8'h01, 8'hE1, 8'h01, 8'hE3, 8'hB6, 8'h01, 8'hE6,
                 8'h01, 8'hE8, 8'hB0, 8'hB4, 8'h01, 8'hEA, 8'hB8, 8'hFF};
        run_load(16, 1'b0, 1'b0);

        // Short load terminated by WrLast.
        run_load(3, 1'b1, 1'b0);

        // Stalled load with random bytes.
        for (int a = 0; a < 16; a++) data[a] = 8'($urandom);
        run_load(6, 1'b1, 1'b1);

        // Reload a single byte after a full program.
        data = '{8'hB7, 8'h01, 8'hE1, 8'h01, 8'hE3, 8'hB6, 8'h01, 8'hE6,
                 8'h01, 8'hE8, 8'hB0, 8'hB4, 8'h01, 8'hEA, 8'hB8, 8'hFF};
        run_load(16, 1'b0, 1'b0);
        data[0] = 8'hF0;
        run_load(1, 1'b1, 1'b0);

        // Randomized lengths and contents.
        for (int r = 0; r < 3; r++) begin
            for (int a = 0; a < 16; a++) data[a] = 8'($urandom);
            run_load(int'($urandom_range(1, 16)), 1'b1, r[0]);
        end

        // Reset in the middle of a load after 5 bytes.
        start_and_clear();
        for (int b = 0; b < 5; b++) begin
            WrValid = 1'b1;
            WrData  = 8'($urandom_range(1, 255));
            tick();
        end
        chk("mid_bytecount", ByteCount, 5);
        Reset = 1'b1;
        tick();
        Reset   = 1'b0;
        WrValid = 1'b0;
        chk("mrst_loading", Loading, 0);
        chk("mrst_wrready", WrReady, 0);
        chk("mrst_done", Done, 0);
        chk("mrst_cpureset", CpuReset, 1);
        chk("mrst_bytecount", ByteCount, 0);
        for (int a = 0; a < 16; a++) exp_mem[a] = 8'h00;
        check_mem("mrst_mem");
        tick();
        chk("mrst_idle", Loading, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
